// File: rtl/sram2_pkg.sv
// Shared types, default window constants and byte-parity helper for the sram2 arbiter.
package sram2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [31:0] SRAM2_BASE_ADDR   = 32'h1000_0000;
  localparam int unsigned SRAM2_DEPTH_WORDS = 1024;

  // Even parity per byte: bit i is the XOR of data byte i.
  function automatic logic [3:0] byte_parity(input logic [31:0] data);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/sram2_parity_gen.sv
// Combinational per-byte parity for the SRAM write path; zero latency, no flow control.
module sram2_parity_gen
  import sram2_pkg::*;
(
  input  logic [31:0] data,
  output logic [3:0]  parity
);

  assign parity = byte_parity(data);

endmodule

// File: rtl/sram2_arbiter.sv
// Round-robin two-port sequencer for the sram2 parity memory: one request in flight, response 1/2/3 cycles after accept.
// Requesters hold valid until ready; optional SRAM2_ARB_RETRY_EN re-reads once on a parity error.
module sram2_arbiter
  import sram2_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = SRAM2_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = SRAM2_DEPTH_WORDS,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [31:0]          req0_address,
  input  logic [31:0]          req0_wdata,
  output logic                 req0_ready,
  output logic                 req0_rvalid,
  output logic [31:0]          req0_rdata,
  output logic                 req0_error,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [31:0]          req1_address,
  input  logic [31:0]          req1_wdata,
  output logic                 req1_ready,
  output logic                 req1_rvalid,
  output logic [31:0]          req1_rdata,
  output logic                 req1_error,
  output logic                 sram_write_enable,
  output logic [31:0]          sram_address,
  output logic [35:0]          sram_data_in,
  input  logic [31:0]          sram_data_out,
  input  logic                 sram_parity_error,
  output logic [ERR_CNT_W-1:0] parity_error_count
);

  // 33-bit end address so a window touching 2^32 does not wrap.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant_port;
  logic        accept;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;
  logic [3:0]  wr_parity;
  logic        lat_port;
  logic        lat_write;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        resp_now;

  // Tie goes to the port that did not win last; a lone requester always wins.
  assign grant_port = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant_port;
  assign req1_ready = accept &&  grant_port;

  assign sel_write = grant_port ? req1_write   : req0_write;
  assign sel_addr  = grant_port ? req1_address : req0_address;
  assign sel_wdata = grant_port ? req1_wdata   : req0_wdata;
  assign sel_legal = (sel_addr >= BASE_ADDR) && ({1'b0, sel_addr} < END_ADDR)
                     && (sel_addr[1:0] == 2'b00);

  sram2_parity_gen u_parity_gen (
    .data   (sel_wdata),
    .parity (wr_parity)
  );

`ifdef SRAM2_ARB_RETRY_EN
  logic retried;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = sel_legal ? ACCESS : RESP;
      ACCESS:  state_nxt = lat_write ? RESP : WAIT;
`ifdef SRAM2_ARB_RETRY_EN
      WAIT:    state_nxt = (sram_parity_error && !retried) ? ACCESS : RESP;
`else
      WAIT:    state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      last_grant         <= 1'b1;
      lat_port           <= 1'b0;
      lat_write          <= 1'b0;
      sram_address       <= '0;
      sram_data_in       <= '0;
      resp_rdata         <= '0;
      resp_error         <= 1'b0;
      parity_error_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_port   <= grant_port;
        last_grant <= grant_port;
        lat_write  <= sel_write;
        resp_rdata <= '0;
        resp_error <= !sel_legal;
        // Illegal requests leave the SRAM-facing registers untouched.
        if (sel_legal) begin
          sram_address <= sel_addr;
          sram_data_in <= {wr_parity, sel_wdata};
        end
      end
      if (state == WAIT && state_nxt == RESP) begin
        resp_error <= sram_parity_error;
        resp_rdata <= sram_parity_error ? 32'd0 : sram_data_out;
        if (sram_parity_error && parity_error_count != '1) begin
          parity_error_count <= parity_error_count + 1'b1;
        end
      end
    end
  end

`ifdef SRAM2_ARB_RETRY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retried <= 1'b0;
    end else if (state == IDLE) begin
      retried <= 1'b0;
    end else if (state == WAIT && sram_parity_error) begin
      retried <= 1'b1;
    end
  end
`endif

  assign sram_write_enable = (state == ACCESS) && lat_write;

  assign resp_now    = (state == RESP);
  assign req0_rvalid = resp_now && !lat_port;
  assign req1_rvalid = resp_now &&  lat_port;
  assign req0_rdata  = req0_rvalid ? resp_rdata : 32'd0;
  assign req1_rdata  = req1_rvalid ? resp_rdata : 32'd0;
  assign req0_error  = req0_rvalid && resp_error;
  assign req1_error  = req1_rvalid && resp_error;

endmodule

// File: tb/tb_sram2_arbiter.sv
// Randomized scoreboard bench for sram2_arbiter with a behavioural SRAM and reference memory model.
module tb_sram2_arbiter;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 1024;
  localparam int          CW    = 8;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } stim_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [CW-1:0] cnt;
    int          acc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [35:0] din;
    int          cyc;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic        req_valid   [2];
  logic        req_write   [2];
  logic [31:0] req_address [2];
  logic [31:0] req_wdata   [2];
  logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid, req0_error, req1_error;
  logic [31:0] req0_rdata, req1_rdata;
  logic        sram_write_enable;
  logic [31:0] sram_address;
  logic [35:0] sram_data_in;
  logic [31:0] sram_data_out;
  logic        sram_parity_error;
  logic [CW-1:0] parity_error_count;

  sram2_arbiter #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .ERR_CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req_valid[0]), .req0_write(req_write[0]), .req0_address(req_address[0]),
    .req0_wdata(req_wdata[0]), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_error(req0_error),
    .req1_valid(req_valid[1]), .req1_write(req_write[1]), .req1_address(req_address[1]),
    .req1_wdata(req_wdata[1]), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_error(req1_error),
    .sram_write_enable(sram_write_enable), .sram_address(sram_address),
    .sram_data_in(sram_data_in), .sram_data_out(sram_data_out),
    .sram_parity_error(sram_parity_error), .parity_error_count(parity_error_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  stim_t stim_q [2][$];
  exp_t  exp_q [$];
  wr_t   wr_q [$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_bad [DEPTH];
  int          last_g = 1;
  int          mcnt = 0;
  bit          in_flight = 1'b0;
  int          corrupt_idx = -1;

  function automatic logic [3:0] bpar(input logic [31:0] d);
    logic [3:0] p = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        p[b] = p[b] ^ d[8*b + k];
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural sram2: one-cycle read latency, parity flag on stored-parity mismatch.
  logic [35:0] mem36 [DEPTH];
  bit          mem_init = 1'b0;
  always @(posedge clock) begin : sram_model
    int idx;
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem36[i] <= '0;
      mem_init <= 1'b1;
    end else begin
      if (corrupt_idx >= 0) mem36[corrupt_idx][32] <= ~mem36[corrupt_idx][32];
      if (sram_address >= BASE && sram_address < BASE + 32'(4 * DEPTH)) begin
        idx = int'((sram_address - BASE) >> 2);
        if (sram_write_enable) mem36[idx] <= sram_data_in;
        sram_data_out     <= mem36[idx][31:0];
        sram_parity_error <= (bpar(mem36[idx][31:0]) != mem36[idx][35:32]);
      end
    end
  end

  // Reference model: decides the full response of a request the moment it is accepted.
  task automatic model_accept(input int p);
    exp_t e;
    logic [31:0] a;
    logic legal;
    int idx;
    a = req_address[p];
    legal = (a >= BASE) && ({1'b0, a} < {1'b0, BASE} + 33'(4 * DEPTH)) && (a[1:0] == 2'b00);
    e.port = p; e.rdata = '0; e.err = 1'b0; e.acc = cyc; e.lat = 1;
    if (!legal) begin
      e.err = 1'b1;
    end else begin
      idx = int'((a - BASE) >> 2);
      if (req_write[p]) begin
        ref_mem[idx] = req_wdata[p];
        ref_bad[idx] = 1'b0;
        e.lat = 2;
        wr_q.push_back('{a, {bpar(req_wdata[p]), req_wdata[p]}, cyc + 1});
      end else begin
        e.err   = ref_bad[idx];
        e.rdata = ref_bad[idx] ? 32'd0 : ref_mem[idx];
        e.lat   = 3;
`ifdef SRAM2_ARB_RETRY_EN
        if (ref_bad[idx]) e.lat = 5;
`endif
        if (e.err && mcnt < (1 << CW) - 1) mcnt++;
      end
    end
    e.cnt = CW'(mcnt);
    exp_q.push_back(e);
  endtask

  // Stimulus: grant prediction and acceptance on the falling edge, input updates just after the rising edge.
  initial begin : driver
    bit acc [2];
    int g;
    stim_t s;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b0; req_write[p] = 1'b0; req_address[p] = '0; req_wdata[p] = '0;
    end
    forever begin
      @(negedge clock);
      acc[0] = 1'b0; acc[1] = 1'b0;
      if (reset_n) begin
        g = -1;
        if (!in_flight) begin
          if (req_valid[0] && req_valid[1]) g = (last_g == 1) ? 0 : 1;
          else if (req_valid[0]) g = 0;
          else if (req_valid[1]) g = 1;
        end
        chk("ready0", 64'(req0_ready), 64'(g == 0));
        chk("ready1", 64'(req1_ready), 64'(g == 1));
        if (g >= 0) begin
          acc[g] = 1'b1;
          last_g = g;
          model_accept(g);
          in_flight <= 1'b1;
        end
      end
      @(posedge clock);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) req_valid[p] = 1'b0;
        if (!req_valid[p] && reset_n && stim_q[p].size() > 0) begin
          s = stim_q[p].pop_front();
          req_valid[p] = 1'b1; req_write[p] = s.wr; req_address[p] = s.addr; req_wdata[p] = s.wdata;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes the SRAM or presents a response.
  initial begin : monitor
    exp_t e;
    wr_t  w;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (sram_write_enable) begin
          if (wr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_we: sram_write_enable=1 addr=%0h, required 0 (cycle %0d)", sram_address, cyc);
          end else begin
            w = wr_q.pop_front();
            chk("we_addr", 64'(sram_address), 64'(w.addr));
            chk("we_data", 64'(sram_data_in), 64'(w.din));
            chk("we_cycle", 64'(cyc), 64'(w.cyc));
          end
        end
        if (req0_rvalid || req1_rvalid) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_rvalid: rvalid=%b%b with nothing outstanding", req1_rvalid, req0_rvalid);
          end else begin
            e = exp_q.pop_front();
            chk("rvalid_port", 64'({req1_rvalid, req0_rvalid}), (e.port == 0) ? 64'd1 : 64'd2);
            chk("rdata", 64'(e.port ? req1_rdata : req0_rdata), 64'(e.rdata));
            chk("error", 64'(e.port ? req1_error : req0_error), 64'(e.err));
            chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            chk("err_count", 64'(parity_error_count), 64'(e.cnt));
          end
          in_flight <= 1'b0;
        end
      end
    end
  end

  task automatic issue(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d);
    stim_q[p].push_back('{wr, a, d});
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((stim_q[0].size() > 0 || stim_q[1].size() > 0 || req_valid[0] || req_valid[1]
            || in_flight || exp_q.size() > 0) && t < budget) begin
      @(negedge clock);
      t++;
    end
    if (t >= budget) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d responses still outstanding after %0d cycles", exp_q.size(), budget);
      stim_q[0].delete(); stim_q[1].delete(); exp_q.delete(); wr_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic corrupt(input int idx);
    if (!ref_bad[idx]) begin
      corrupt_idx = idx;
      @(posedge clock);
      #1;
      corrupt_idx = -1;
      ref_bad[idx] = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
    if (r == 1) return BASE - 32'(4 * $urandom_range(1, 4));
    if (r == 2) return BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
    return BASE + 32'(4 * $urandom_range(0, 63));
  endfunction

  initial begin : main
    int t;
    for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; ref_bad[i] = 1'b0; end
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_we", 64'(sram_write_enable), 64'd0);
    chk("reset_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'd0);
    chk("reset_count", 64'(parity_error_count), 64'd0);
    chk("reset_sram_data_in", 64'(sram_data_in), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    issue(0, 1'b1, BASE, 32'hA5A5_A5A5);
    drain(50);
    issue(0, 1'b0, BASE, 32'd0);
    drain(50);

    issue(1, 1'b1, BASE + 32'd8, 32'h0000_00FF);
    drain(50);
    corrupt(2);
    issue(1, 1'b0, BASE + 32'd8, 32'd0);
    drain(50);

    for (int i = 0; i < 12; i++) begin
      issue(0, 1'b0, BASE + 32'(4 * $urandom_range(0, 63)), 32'd0);
      issue(1, 1'b0, BASE + 32'(4 * $urandom_range(0, 63)), 32'd0);
    end
    drain(400);

    issue(1, 1'b0, 32'h0FFF_FFFC, 32'd0);
    issue(1, 1'b1, 32'h1000_1000, $urandom);
    issue(1, 1'b0, 32'h1000_0002, 32'd0);
    drain(50);

    for (int r = 0; r < 8; r++) begin
      corrupt($urandom_range(0, 63));
      for (int i = 0; i < 12; i++)
        issue($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      drain(600);
    end

    issue(0, 1'b1, BASE + 32'(4 * 1000), 32'hDEAD_BEEF);
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!sram_write_enable && t < 50);
    if (!sram_write_enable) begin
      n_checks++; n_errors++;
      $display("FAIL reset_setup: sram_write_enable never rose within 50 cycles");
    end
    #1 reset_n = 1'b0;
    #1;
    chk("reset_async_we", 64'(sram_write_enable), 64'd0);
    exp_q.delete(); wr_q.delete(); stim_q[0].delete(); stim_q[1].delete();
    in_flight <= 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    last_g = 1; mcnt = 0;
    repeat (2) begin
      @(negedge clock);
      chk("reset_hold_rvalid", 64'({req1_rvalid, req0_rvalid}), 64'd0);
      chk("reset_hold_count", 64'(parity_error_count), 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, BASE + 32'(4 * $urandom_range(0, 63)), 32'd0);
      issue(1, 1'b0, BASE + 32'(4 * $urandom_range(0, 63)), 32'd0);
    end
    drain(200);

    corrupt(70);
    for (int i = 0; i < (1 << CW) + 3; i++)
      issue($urandom_range(0, 1), 1'b0, BASE + 32'(4 * 70), 32'd0);
    drain(6000);
    chk("count_saturated", 64'(parity_error_count), 64'((1 << CW) - 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
